// File: rtl/rom_dl_pkg.sv
// Shared types and constants for the ROM download controller (region map,
// FSM states, reference checksum used when ROM_DL_CKSUM_EN is defined).
package rom_dl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STALL,
        ST_HOLD,
        ST_DONE
    } dl_state_t;

    typedef enum logic [2:0] {
        RGN_CPU,
        RGN_SND,
        RGN_CHAR,
        RGN_SPRITE,
        RGN_PROM,
        RGN_NONE
    } rgn_t;

    localparam logic [15:0] CPU_BASE     = 16'h0000;
    localparam logic [15:0] SND_BASE     = 16'h8000;
    localparam logic [15:0] CHAR_BASE    = 16'hA000;
    localparam logic [15:0] SPRITE_BASE  = 16'hC000;
    localparam logic [15:0] PROM_BASE    = 16'hE000;

    // Inclusive upper address of each region.
    localparam logic [15:0] CPU_LIMIT    = 16'h7FFF;
    localparam logic [15:0] SND_LIMIT    = 16'h9FFF;
    localparam logic [15:0] CHAR_LIMIT   = 16'hBFFF;
    localparam logic [15:0] SPRITE_LIMIT = 16'hDFFF;
    localparam logic [15:0] PROM_LIMIT   = 16'hE21F;

    localparam logic [7:0]  CKSUM_EXP    = 8'hF0;

    function automatic logic [4:0] rgn_onehot(input rgn_t r);
        logic [4:0] oh;
        case (r)
            RGN_CPU:    oh = 5'b00001;
            RGN_SND:    oh = 5'b00010;
            RGN_CHAR:   oh = 5'b00100;
            RGN_SPRITE: oh = 5'b01000;
            RGN_PROM:   oh = 5'b10000;
            default:    oh = '0;
        endcase
        return oh;
    endfunction

    function automatic logic [16:0] sat_inc(input logic [16:0] v);
        return (v == '1) ? v : v + 17'd1;
    endfunction

endpackage

// File: rtl/rom_dl_decode.sv
// Combinational region decoder: one-hot region, region-relative offset and
// out-of-map flag for a download byte address.
module rom_dl_decode
    import rom_dl_pkg::*;
(
    input  logic [24:0] addr,
    output logic [4:0]  rgn_oh,
    output logic [15:0] offset,
    output logic        oom
);

    logic [15:0] a16;
    logic [15:0] base;
    rgn_t        rgn;

    assign a16 = addr[15:0];

    always_comb begin
        rgn  = RGN_NONE;
        base = '0;
        if (a16 <= CPU_LIMIT) begin
            rgn  = RGN_CPU;
            base = CPU_BASE;
        end else if (a16 <= SND_LIMIT) begin
            rgn  = RGN_SND;
            base = SND_BASE;
        end else if (a16 <= CHAR_LIMIT) begin
            rgn  = RGN_CHAR;
            base = CHAR_BASE;
        end else if (a16 <= SPRITE_LIMIT) begin
            rgn  = RGN_SPRITE;
            base = SPRITE_BASE;
        end else if (a16 <= PROM_LIMIT) begin
            rgn  = RGN_PROM;
            base = PROM_BASE;
        end
        if (addr[24:16] != '0) begin
            rgn  = RGN_NONE;
            base = '0;
        end
        oom    = (rgn == RGN_NONE);
        offset = a16 - base;
        rgn_oh = rgn_onehot(rgn);
    end

endmodule

// File: rtl/rom_dl_ctrl.sv
// ROM download controller: routes hps_io bytes to region write ports, stalls on
// busy targets and holds the core in reset until a valid image is loaded.
// Optional ROM_DL_CKSUM_EN adds an 8-bit image checksum (dl_sum) to the pass check.
module rom_dl_ctrl
    import rom_dl_pkg::*;
#(
    parameter logic [16:0] EXP_BYTES = 17'd57888,
    parameter logic [7:0]  HOLD_CYC  = 8'd16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic [4:0]  tgt_busy,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic [4:0]  dn_we,
    output logic        core_reset,
    output logic        dl_done,
    output logic        dl_err
`ifdef ROM_DL_CKSUM_EN
    ,
    output logic [7:0]  dl_sum
`endif
);

    dl_state_t   state;
    logic        dl_prev;
    logic [16:0] byte_cnt;
    logic        err_flag;
    logic [7:0]  hold_cnt;
    logic [4:0]  held_we;
    logic        fall_pend;

    logic [4:0]  dec_we;
    logic [15:0] dec_off;
    logic        dec_oom;
    logic        dl_rise;
    logic        dl_fall;
    logic        stall_req;
    logic        hold_last;
    logic        img_ok;

    rom_dl_decode u_decode (
        .addr   (ioctl_addr),
        .rgn_oh (dec_we),
        .offset (dec_off),
        .oom    (dec_oom)
    );

    assign dl_rise   = ioctl_download & ~dl_prev;
    assign dl_fall   = ~ioctl_download & dl_prev;
    assign stall_req = ioctl_wr & ~dec_oom & (|(dec_we & tgt_busy));
    assign hold_last = ({1'b0, hold_cnt} + 9'd1) >= {1'b0, HOLD_CYC};

`ifdef ROM_DL_CKSUM_EN
    assign img_ok = (byte_cnt == EXP_BYTES) && !err_flag && (dl_sum == CKSUM_EXP);
`else
    assign img_ok = (byte_cnt == EXP_BYTES) && !err_flag;
`endif

    // dl_prev resets high so a download already active at reset release is
    // not mistaken for a new rising edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            dl_prev    <= 1'b1;
            byte_cnt   <= '0;
            err_flag   <= 1'b0;
            hold_cnt   <= '0;
            held_we    <= '0;
            fall_pend  <= 1'b0;
            dn_we      <= '0;
            dn_addr    <= '0;
            dn_data    <= '0;
            ioctl_wait <= 1'b0;
            core_reset <= 1'b1;
            dl_done    <= 1'b0;
            dl_err     <= 1'b0;
`ifdef ROM_DL_CKSUM_EN
            dl_sum     <= '0;
`endif
        end else begin
            dl_prev <= ioctl_download;
            dn_we   <= '0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (dl_rise) begin
                        state      <= ST_LOAD;
                        byte_cnt   <= '0;
                        err_flag   <= 1'b0;
                        fall_pend  <= 1'b0;
                        core_reset <= 1'b1;
                        dl_done    <= 1'b0;
                        dl_err     <= 1'b0;
`ifdef ROM_DL_CKSUM_EN
                        dl_sum     <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (ioctl_wr) begin
                        if (dec_oom) begin
                            err_flag <= 1'b1;
                        end else begin
                            // Address/data are captured now; a stalled byte only delays dn_we.
                            dn_addr <= dec_off;
                            dn_data <= ioctl_dout;
                            if (stall_req) begin
                                held_we    <= dec_we;
                                ioctl_wait <= 1'b1;
                                fall_pend  <= dl_fall;
                                state      <= ST_STALL;
                            end else begin
                                dn_we    <= dec_we;
                                byte_cnt <= sat_inc(byte_cnt);
`ifdef ROM_DL_CKSUM_EN
                                dl_sum   <= dl_sum + ioctl_dout;
`endif
                            end
                        end
                    end
                    if (dl_fall && !stall_req) begin
                        hold_cnt <= '0;
                        state    <= ST_HOLD;
                    end
                end
                ST_STALL: begin
                    if (dl_fall) begin
                        fall_pend <= 1'b1;
                    end
                    if (!(|(held_we & tgt_busy))) begin
                        dn_we      <= held_we;
                        ioctl_wait <= 1'b0;
                        byte_cnt   <= sat_inc(byte_cnt);
`ifdef ROM_DL_CKSUM_EN
                        dl_sum     <= dl_sum + dn_data;
`endif
                        if (fall_pend || dl_fall) begin
                            hold_cnt <= '0;
                            state    <= ST_HOLD;
                        end else begin
                            state    <= ST_LOAD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_last) begin
                        state      <= ST_DONE;
                        dl_done    <= img_ok;
                        dl_err     <= !img_ok;
                        core_reset <= !img_ok;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
